// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, requester indices and arbiter state encoding for the
// CTRL_MEMORY port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_BITS    = 6;
    localparam int BLOCK_WIDTH  = 8;
    localparam int WORD_BITS    = 16;
    localparam int LINE_BITS    = WORD_BITS * BLOCK_WIDTH * BLOCK_WIDTH;
    localparam int MAX_BURST    = 8;
    localparam int LEN_BITS     = 4;
    localparam int STARVE_LIMIT = 16;
    localparam int STARVE_BITS  = $clog2(STARVE_LIMIT + 1);

    localparam int REQ_CTRL = 0;
    localparam int REQ_HOST = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // A zero length still moves one beat; anything above MAX_BURST is clamped.
    function automatic logic [LEN_BITS-1:0] effective_len(input logic [LEN_BITS-1:0] len);
        logic [LEN_BITS-1:0] clamped;
        if (len == '0) begin
            clamped = LEN_BITS'(1);
        end else if (len > LEN_BITS'(MAX_BURST)) begin
            clamped = LEN_BITS'(MAX_BURST);
        end else begin
            clamped = len;
        end
        return clamped;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_counter.sv
// Burst bookkeeping for the owning requester: latches the effective burst
// length at the grant decision, counts accepted beats and flags the last
// beat and an early release (two consecutive stalled granted cycles).
module arb_burst_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [LEN_BITS-1:0] i_len,
    input  logic                i_beat,
    input  logic                i_stall,
    output logic                o_last_beat,
    output logic                o_early_release
);

    logic [LEN_BITS-1:0] r_eff_len;
    logic [LEN_BITS-1:0] r_count;
    logic                r_stall_seen;

    // Load a new burst on the decision cycle, otherwise track beats and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eff_len    <= '0;
            r_count      <= '0;
            r_stall_seen <= 1'b0;
        end else if (i_load) begin
            r_eff_len    <= effective_len(i_len);
            r_count      <= '0;
            r_stall_seen <= 1'b0;
        end else begin
            if (i_beat) begin
                r_count <= r_count + LEN_BITS'(1);
            end
            r_stall_seen <= i_stall;
        end
    end

    assign o_last_beat     = i_beat & (r_count == (r_eff_len - LEN_BITS'(1)));
    assign o_early_release = i_stall & r_stall_seen;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single CTRL_MEMORY access port. CTRL_CELL has
// fixed priority, the host gets an anti-starvation override, grants last for
// a burst, and read data is returned with a per-requester valid.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [LEN_BITS-1:0]  len0,
    input  logic [LEN_BITS-1:0]  len1,
    input  logic [ADDR_BITS-1:0] addr0,
    input  logic [ADDR_BITS-1:0] addr1,
    input  logic [LINE_BITS-1:0] wdata0,
    input  logic [LINE_BITS-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [LINE_BITS-1:0] rdata,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata
);

    arb_state_e             r_state;
    arb_state_e             w_state_next;
    logic [STARVE_BITS-1:0] r_starve;
    logic [ADDR_BITS-1:0]   r_last_addr;
    logic                   r_rvalid0;
    logic                   r_rvalid1;

    logic                   w_beat0;
    logic                   w_beat1;
    logic                   w_stall;
    logic                   w_host_starved;
    logic                   w_load;
    logic [LEN_BITS-1:0]    w_load_len;
    logic                   w_last_beat;
    logic                   w_early_release;

    // Grants are a direct decode of the registered owner state.
    assign gnt0 = (r_state == ST_OWN0);
    assign gnt1 = (r_state == ST_OWN1);

    assign w_beat0        = gnt0 & req0;
    assign w_beat1        = gnt1 & req1;
    assign w_stall        = (gnt0 & ~req0) | (gnt1 & ~req1);
    assign w_host_starved = (r_starve >= STARVE_BITS'(STARVE_LIMIT));

    arb_burst_counter u_burst_counter (
        .clk             (clk),
        .rst_n           (rst),
        .i_load          (w_load),
        .i_len           (w_load_len),
        .i_beat          (w_beat0 | w_beat1),
        .i_stall         (w_stall),
        .o_last_beat     (w_last_beat),
        .o_early_release (w_early_release)
    );

    // Owner decision in IDLE; a burst ends on its last beat or an early release.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_len   = len0;
        case (r_state)
            ST_IDLE: begin
                if (req1 && w_host_starved) begin
                    w_state_next = ST_OWN1;
                    w_load       = 1'b1;
                    w_load_len   = len1;
                end else if (req0) begin
                    w_state_next = ST_OWN0;
                    w_load       = 1'b1;
                    w_load_len   = len0;
                end else if (req1) begin
                    w_state_next = ST_OWN1;
                    w_load       = 1'b1;
                    w_load_len   = len1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (w_last_beat || w_early_release) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Owner state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Host wait counter: saturates at the limit, cleared by a host beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_beat1) begin
            r_starve <= '0;
        end else if (req1 && !gnt1 && !w_host_starved) begin
            r_starve <= r_starve + STARVE_BITS'(1);
        end
    end

    // Accepted read beats return their valid one cycle later, with the memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_beat0 & ~we0;
            r_rvalid1 <= w_beat1 & ~we1;
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = mem_rdata;

    // Memory port follows the granted requester; the address parks when idle.
    always_comb begin
        mem_addr  = r_last_addr;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_write = req0 & we0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_write = req1 & we1;
        end
    end

    // Remember the last driven address so it holds while nobody owns the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_addr <= '0;
        end else begin
            r_last_addr <= mem_addr;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single CTRL_MEMORY access port (write/read address, write line, read line A) between two requesters.
- Requester 0: CTRL_CELL, which issues operand reads and writes back tile results.
- Requester 1: the host/program loader, which bulk-loads and reads back whole memory lines.
- Fixed priority to CTRL_CELL, an anti-starvation override for the host, and burst grants; it returns read data tagged to the owning requester.

Parameters:
- ADDR_BITS, 6, memory line address width
- BLOCK_WIDTH, 8, tile array side; one line = BLOCK_WIDTH**2 words
- WORD_BITS, 16, word width; LINE_BITS = WORD_BITS*BLOCK_WIDTH**2
- MAX_BURST, 8, maximum beats per grant
- LEN_BITS, 4, burst length field width (clog2(MAX_BURST)+1)
- STARVE_LIMIT, 16, host wait cycles before it overrides CTRL priority

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req0, req1  in  1  request / beat-valid per requester
- we0, we1  in  1  beat is a write (1) or read (0)
- len0, len1  in  LEN_BITS  burst length, sampled at grant decision
- addr0, addr1  in  ADDR_BITS  beat address
- wdata0, wdata1  in  LINE_BITS  write line
- gnt0, gnt1  out  1  grant; a beat is accepted when gntX & reqX
- rvalid0, rvalid1  out  1  read line valid for that requester
- rdata  out  LINE_BITS  read line, shared; qualified by rvalidX
- mem_write  out  1  to CTRL_MEMORY write
- mem_addr  out  ADDR_BITS  to CTRL_MEMORY addr_a and addr_i
- mem_wdata  out  LINE_BITS  to CTRL_MEMORY write data
- mem_rdata  in  LINE_BITS  from CTRL_MEMORY port A, valid 1 cycle after address

Behaviour:
- Reset values (rst low, async): state IDLE; gnt0/gnt1=0; rvalid0/rvalid1=0; beat counter=0; starve counter=0; mem_write=0; mem_addr=0.
- States: IDLE, OWN0, OWN1.
- IDLE arbitration:
  - req1 with starve counter >= STARVE_LIMIT -> OWN1.
  - Otherwise req0 -> OWN0.
  - Otherwise req1 -> OWN1.
  - No request -> stay in IDLE.
  - Grant is registered: gntX is high the cycle after the decision. Latency from IDLE request to grant is 1 cycle.
- Burst length:
  - Latched at the decision as effective_len = (len==0) ? 1 : min(len, MAX_BURST).
  - The beat counter counts accepted beats only. Cycles with req low while granted are stall cycles, not beats.
- Burst termination (both return to IDLE with gnt low the next cycle, giving a 1-cycle bubble between owners):
  - Accepted beat with count == effective_len-1.
  - Requester holds req low for 2 consecutive granted cycles (early release).
- Memory drive, combinational from the granted requester:
  - mem_addr = addrX.
  - mem_wdata = wdataX.
  - mem_write = gntX & reqX & weX.
  - When no grant: mem_write=0, and mem_addr holds its last value.
- Read return:
  - An accepted read beat sets rvalidX in the next cycle.
  - rdata = mem_rdata, passed through.
  - Back-to-back reads give a continuous rvalid stream in order.
  - A read accepted on the last beat still returns its rvalid after the grant drops.
- Starve counter:
  - Increments each cycle that req1 is high and gnt1 is low; saturates at STARVE_LIMIT.
  - Clears on the first accepted host beat.
- Simultaneous req0 and req1 in IDLE with the counter below the limit: CTRL wins.
- Requester changing we mid-burst is legal; each beat is independent.
- Reset mid-burst: grant drops immediately; pending rvalid is discarded; no memory write occurs while rst is low.

Decomposition:
- Shared package (coreflow constants, e.g. coreflow_pkg):
  - ADDR_BITS, WORD_BITS, BLOCK_WIDTH, LINE_BITS.
  - Requester index constants REQ_CTRL=0, REQ_HOST=1.
  - Arbiter state encoding (IDLE/OWN0/OWN1).
- Sub-module arb_burst_counter: latches effective_len, counts accepted beats, and flags the last beat and early release. It is instantiated once.

Test Plan:
- Reset with req0=1 held: gnt0=0 during reset; after release, gnt0=1 exactly 1 cycle later.
- req0 and req1 asserted together, len0=3: CTRL gets 3 writes at addr 5,6,7 with mem_write high 3 cycles. One IDLE bubble follows, then gnt1=1.
- Host reads, len1=4, addr 0..3: rvalid1 is high for 4 consecutive cycles, each 1 cycle after its accepted beat. Returned lines match the preloaded memory lines 0..3.
- req0 held continuously with len0=8 while req1 held: after the host has waited 16 cycles, the next IDLE decision grants OWN1 despite req0.
- len0=0 -> single beat; len0=15 -> clamped to 8 beats. When granted, req0 low for 2 cycles mid-burst -> early release to IDLE.
- Assert rst mid-burst after 2 of 5 beats: gnt0, rvalid0 and mem_write go low immediately. After release the arbiter is in IDLE and no stray write occurs.
